// File: rtl/keypad_pkg.sv
// Shared types and keymap for the 4x4 matrix keypad scanner.
package keypad_pkg;

  // Outcome of one full four-column scan
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_t;

  // Debounced key state
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_state_t;

  // Hex legend of the Pmod KYPD: row r, column c
  function automatic logic [3:0] decode_key(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] w_code;
    case ({row_idx, col_idx})
      4'b00_00: w_code = 4'h1;
      4'b00_01: w_code = 4'h2;
      4'b00_10: w_code = 4'h3;
      4'b00_11: w_code = 4'hA;
      4'b01_00: w_code = 4'h4;
      4'b01_01: w_code = 4'h5;
      4'b01_10: w_code = 4'h6;
      4'b01_11: w_code = 4'hB;
      4'b10_00: w_code = 4'h7;
      4'b10_01: w_code = 4'h8;
      4'b10_10: w_code = 4'h9;
      4'b10_11: w_code = 4'hC;
      4'b11_00: w_code = 4'h0;
      4'b11_01: w_code = 4'hF;
      4'b11_10: w_code = 4'hE;
      default:  w_code = 4'hD;
    endcase
    return w_code;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins plus decoded key outputs; master = scanner, slave = keypad/consumer.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_a;
  logic [3:0] digit_b;
  logic [3:0] digit_c;
  logic [3:0] digit_d;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held,
           digit_a, digit_b, digit_c, digit_d
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held,
           digit_a, digit_b, digit_c, digit_d
  );
endinterface

// File: rtl/keypad_col_scan.sv
// Column driver and row sampler: one full scan every 4*SCAN_TICKS cycles,
// classified as NONE / SINGLE(code) / MULTI and reported with a strobe.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 25000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_scan_done,
  output scan_res_t  o_result,
  output logic [3:0] o_code
);

  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_col_idx;
  logic [3:0]        r_col;
  logic [3:0]        r_row_s1;
  logic [3:0]        r_row_s2;
  logic [1:0]        r_acc_cnt;   // keys seen so far this scan, saturating at 2
  logic [3:0]        r_acc_code;
  logic              r_scan_done;
  scan_res_t         r_result;
  logic [3:0]        r_code;

  logic              w_last;
  logic [3:0]        w_hits;
  logic [2:0]        w_col_cnt;
  logic [2:0]        w_sum_raw;
  logic [1:0]        w_sum;
  logic [1:0]        w_row_idx;
  logic [3:0]        w_code_nxt;

  assign w_last    = (r_tick == TICK_LAST);
  assign w_hits    = ~r_row_s2;
  assign w_col_cnt = {2'b00, w_hits[0]} + {2'b00, w_hits[1]} +
                     {2'b00, w_hits[2]} + {2'b00, w_hits[3]};
  assign w_sum_raw = {1'b0, r_acc_cnt} + w_col_cnt;
  assign w_sum     = (w_sum_raw >= 3'd2) ? 2'd2 : w_sum_raw[1:0];

  // Row index of the pressed key when this column has exactly one hit
  always_comb begin
    w_row_idx = 2'd0;
    if (w_hits[1]) w_row_idx = 2'd1;
    if (w_hits[2]) w_row_idx = 2'd2;
    if (w_hits[3]) w_row_idx = 2'd3;
  end

  assign w_code_nxt = (r_acc_cnt == 2'd0 && w_col_cnt == 3'd1) ?
                      decode_key(w_row_idx, r_col_idx) : r_acc_code;

  // Tick counter, column rotation, row synchronizer and per-scan accumulation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick      <= '0;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
      r_acc_cnt   <= 2'd0;
      r_acc_code  <= 4'h0;
      r_scan_done <= 1'b0;
      r_result    <= RES_NONE;
      r_code      <= 4'h0;
    end else begin
      r_row_s1    <= i_row;
      r_row_s2    <= r_row_s1;
      r_scan_done <= 1'b0;
      if (w_last) begin
        r_tick    <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= {r_col[2:0], r_col[3]};
        if (r_col_idx == 2'd3) begin
          r_acc_cnt   <= 2'd0;
          r_acc_code  <= 4'h0;
          r_scan_done <= 1'b1;
          r_code      <= w_code_nxt;
          case (w_sum)
            2'd0:    r_result <= RES_NONE;
            2'd1:    r_result <= RES_SINGLE;
            default: r_result <= RES_MULTI;
          endcase
        end else begin
          r_acc_cnt  <= w_sum;
          r_acc_code <= w_code_nxt;
        end
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign o_col       = r_col;
  assign o_scan_done = r_scan_done;
  assign o_result    = r_result;
  assign o_code      = r_code;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner top: debounces whole-scan results, accepts single key
// presses and keeps the last four accepted keys for the display driver.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 25000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic     clk_25mhz,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);

  logic       w_scan_done;
  scan_res_t  w_res;
  logic [3:0] w_code;
  logic [3:0] w_col;

  logic [STB_W-1:0] r_stable;
  scan_res_t        r_prev_res;
  logic [3:0]       r_prev_code;
  key_state_t       r_state;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;
  logic [3:0]       r_digit_a;
  logic [3:0]       r_digit_b;
  logic [3:0]       r_digit_c;
  logic [3:0]       r_digit_d;

  logic             w_same;
  logic [STB_W-1:0] w_stable_nxt;
  logic             w_stable;
  logic             w_sat_edge;

  keypad_col_scan #(
    .SCAN_TICKS (SCAN_TICKS)
  ) u_col_scan (
    .i_clk       (clk_25mhz),
    .i_rst       (reset),
    .i_row       (kp.row),
    .o_col       (w_col),
    .o_scan_done (w_scan_done),
    .o_result    (w_res),
    .o_code      (w_code)
  );

  // The key code only distinguishes results when a single key is seen
  assign w_same       = (w_res == r_prev_res) &&
                        ((w_res != RES_SINGLE) || (w_code == r_prev_code));
  assign w_stable_nxt = !w_same ? STB_W'(1) :
                        (r_stable == STB_MAX) ? STB_MAX : r_stable + 1'b1;
  assign w_stable     = (w_stable_nxt == STB_MAX);
  assign w_sat_edge   = w_stable && (r_stable != STB_MAX);

  // Debounce counter, press/release FSM and digit history
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_stable    <= '0;
      r_prev_res  <= RES_NONE;
      r_prev_code <= 4'h0;
      r_state     <= ST_RELEASED;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_digit_a   <= 4'h0;
      r_digit_b   <= 4'h0;
      r_digit_c   <= 4'h0;
      r_digit_d   <= 4'h0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        r_stable    <= w_stable_nxt;
        r_prev_res  <= w_res;
        r_prev_code <= w_code;
        case (r_state)
          ST_RELEASED: begin
            if (w_sat_edge && w_res == RES_SINGLE) begin
              r_state     <= ST_PRESSED;
              r_key_code  <= w_code;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_digit_a   <= r_digit_b;
              r_digit_b   <= r_digit_c;
              r_digit_c   <= r_digit_d;
              r_digit_d   <= w_code;
            end
          end
          default: begin
            if (w_stable && w_res == RES_NONE) begin
              r_state    <= ST_RELEASED;
              r_key_held <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign kp.col       = w_col;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;
  assign kp.digit_a   = r_digit_a;
  assign kp.digit_b   = r_digit_b;
  assign kp.digit_c   = r_digit_c;
  assign kp.digit_d   = r_digit_d;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: closed-contact keypad model, per-scan behavioural
// reference of the debounce/accept rules, directed and random scenarios.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 3;
  localparam int R_NONE  = 100;
  localparam int R_MULTI = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;     // bit r*4+c = key at row r, column c closed

  always #5 clk = ~clk;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk_25mhz (clk),
    .reset     (rst),
    .kp        (kp)
  );

  // Closed key pulls its row low while its column is driven low
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int n_pulses = 0;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  // Reference state
  int         m_prev;
  int         m_cnt;
  bit         m_pressed;
  bit         m_pulse;
  logic [3:0] m_code;
  logic [3:0] m_dig [4];

  function automatic int scan_result(input logic [15:0] k);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (n == 0) return R_NONE;
    if (n > 1) return R_MULTI;
    return int'(keymap[idx]);
  endfunction

  task automatic model_reset();
    m_prev = R_NONE; m_cnt = 0; m_pressed = 0; m_pulse = 0; m_code = 4'h0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int res = scan_result(k);
    bit was_full = (m_cnt == DB);
    m_pulse = 0;
    if (res == m_prev) begin
      if (m_cnt < DB) m_cnt++;
    end else begin
      m_cnt = 1;
    end
    m_prev = res;
    if (!m_pressed && res < 16 && m_cnt == DB && !was_full) begin
      m_pressed = 1; m_pulse = 1; m_code = 4'(res);
      m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = 4'(res);
    end else if (m_pressed && res == R_NONE && m_cnt == DB) begin
      m_pressed = 0;
    end
  endtask

  // Enter at the negedge one cycle into a scan; leave at the same phase of the next scan
  task automatic run_scan(input logic [15:0] k);
    keys = k;
    model_scan(k);
    repeat (4*ST - 1) begin
      @(negedge clk);
      checks++;
      if (kp.key_valid !== 1'b0) begin
        errors++; $display("FAIL mid_scan_valid: got %b want 0 at %0t", kp.key_valid, $time);
      end
    end
    @(negedge clk);
    if (kp.key_valid === 1'b1) n_pulses++;
    checks++;
    if (kp.key_valid !== m_pulse) begin
      errors++; $display("FAIL scan_valid: got %b want %b at %0t", kp.key_valid, m_pulse, $time);
    end
    checks++;
    if (kp.key_held !== m_pressed) begin
      errors++; $display("FAIL scan_held: got %b want %b at %0t", kp.key_held, m_pressed, $time);
    end
    checks++;
    if (kp.key_code !== m_code) begin
      errors++; $display("FAIL scan_code: got %h want %h at %0t", kp.key_code, m_code, $time);
    end
    checks++;
    if ({kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d} !== {m_dig[0], m_dig[1], m_dig[2], m_dig[3]}) begin
      errors++;
      $display("FAIL scan_digits: got %h%h%h%h want %h%h%h%h at %0t",
               kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d,
               m_dig[0], m_dig[1], m_dig[2], m_dig[3], $time);
    end
  endtask

  // Reset, release on a negedge, then advance one cycle into scan 0
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (kp.col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", kp.col); end
    checks++;
    if (kp.key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", kp.key_code); end
    checks++;
    if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b held=%b want 0 0", kp.key_valid, kp.key_held);
    end
    checks++;
    if ({kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d} !== 16'h0) begin
      errors++; $display("FAIL reset_digits: got %h%h%h%h want 0000", kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d);
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / ST) % 4));
      checks++;
      if (kp.col !== exp_col) begin
        errors++; $display("FAIL col_rotate: cycle %0d got %b want %b", k, kp.col, exp_col);
      end
    end
  endtask

  task automatic test_single_press();
    int p0;
    do_reset();
    p0 = n_pulses;
    for (int s = 0; s < 6; s++) run_scan(16'h1 << 5);   // '5' at r1,c1
    checks++;
    if (n_pulses - p0 != 1) begin errors++; $display("FAIL press5_pulses: got %0d want 1", n_pulses - p0); end
    checks++;
    if (kp.key_code !== 4'h5 || kp.digit_d !== 4'h5 || kp.key_held !== 1'b1) begin
      errors++; $display("FAIL press5_state: got code=%h d=%h held=%b want 5 5 1", kp.key_code, kp.digit_d, kp.key_held);
    end
    for (int s = 0; s < 3; s++) run_scan(16'h0);
    checks++;
    if (kp.key_held !== 1'b0) begin errors++; $display("FAIL release5_held: got %b want 0", kp.key_held); end
  endtask

  task automatic test_bounce();
    int p0;
    do_reset();
    p0 = n_pulses;
    for (int s = 0; s < 4; s++) run_scan((s % 2 == 0) ? (16'h1 << 9) : 16'h0);   // '8' at r2,c1
    checks++;
    if (n_pulses != p0) begin errors++; $display("FAIL bounce_early: got %0d pulses want 0", n_pulses - p0); end
    run_scan(16'h1 << 9);
    run_scan(16'h1 << 9);
    checks++;
    if (n_pulses != p0) begin errors++; $display("FAIL bounce_two_scans: got %0d pulses want 0", n_pulses - p0); end
    run_scan(16'h1 << 9);
    checks++;
    if (n_pulses - p0 != 1 || kp.key_code !== 4'h8) begin
      errors++; $display("FAIL bounce_accept: got %0d pulses code=%h want 1 pulse code=8", n_pulses - p0, kp.key_code);
    end
  endtask

  task automatic test_multi();
    int p0;
    do_reset();
    p0 = n_pulses;
    for (int s = 0; s < 5; s++) run_scan(16'h0003);   // '1' and '2'
    checks++;
    if (n_pulses != p0 || kp.key_held !== 1'b0) begin
      errors++; $display("FAIL multi: got %0d pulses held=%b want 0 0", n_pulses - p0, kp.key_held);
    end
  endtask

  task automatic test_digits();
    int seq [5] = '{0, 1, 2, 3, 12};   // keys 1,2,3,A,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 3; s++) run_scan(16'h1 << seq[i]);
      for (int s = 0; s < 3; s++) run_scan(16'h0);
      if (i == 3) begin
        checks++;
        if ({kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d} !== 16'h123A) begin
          errors++; $display("FAIL digits_123A: got %h%h%h%h want 123A", kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d);
        end
      end
    end
    checks++;
    if ({kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d} !== 16'h23A0) begin
      errors++; $display("FAIL digits_23A0: got %h%h%h%h want 23A0", kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d);
    end
  endtask

  task automatic test_reset_mid_press();
    int p0;
    do_reset();
    for (int s = 0; s < 4; s++) run_scan(16'h1 << 13);   // 'F' at r3,c1
    checks++;
    if (kp.key_held !== 1'b1) begin errors++; $display("FAIL f_held_before_reset: got %b want 1", kp.key_held); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (kp.key_held !== 1'b0 || kp.key_valid !== 1'b0 || kp.key_code !== 4'h0 || kp.col !== 4'b1110 ||
        {kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_clear: got held=%b valid=%b code=%h col=%b digits=%h%h%h%h want 0 0 0 1110 0000",
               kp.key_held, kp.key_valid, kp.key_code, kp.col, kp.digit_a, kp.digit_b, kp.digit_c, kp.digit_d);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    p0 = n_pulses;
    for (int s = 0; s < 3; s++) run_scan(16'h1 << 13);
    checks++;
    if (n_pulses - p0 != 1 || kp.key_code !== 4'hF) begin
      errors++; $display("FAIL f_after_reset: got %0d pulses code=%h want 1 F", n_pulses - p0, kp.key_code);
    end
  endtask

  task automatic test_random();
    logic [15:0] ks = '0;
    do_reset();
    for (int s = 0; s < 60; s++) begin
      if (s == 0 || $urandom_range(99) >= 65) begin
        int q = int'($urandom_range(99));
        if (q < 40)      ks = 16'h0;
        else if (q < 85) ks = 16'h1 << $urandom_range(15);
        else             ks = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
      end
      run_scan(ks);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_digits();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
